// File: rtl/class_scan_ctrl.sv
// Scans NUM_CLASSES scores from an external bank, reports the arg-max index and score.
// Latency: Done pulses NUM_CLASSES+1 cycles after the accepted Start edge; restartable every NUM_CLASSES+2 cycles.
// No backpressure: Start while Busy is dropped; Abort cancels the scan in flight without updating results.
module class_scan_ctrl #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 26
) (
  input  logic               clk,
  input  logic               GlobalReset,
  input  logic               Start,
  input  logic               Abort,
  output logic               ScoreRdEn,
  output logic [3:0]         ScoreAddr,
  input  logic [SCORE_W-1:0] ScoreData,
  output logic               Busy,
  output logic               Done,
  output logic [3:0]         ClassOut,
  output logic [SCORE_W-1:0] MaxScore
);

  localparam logic [3:0] LAST_ADDR = 4'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t               state;
  // cap_vld/cap_idx track the read issued last cycle, whose data is on ScoreData now
  logic                 cap_vld;
  logic [3:0]           cap_idx;
  logic [SCORE_W-1:0]   run_max;
  logic [3:0]           run_idx;
  logic                 take;
  logic [SCORE_W-1:0]   nxt_max;
  logic [3:0]           nxt_idx;

  // Running-max update: index 0 seeds unconditionally, later scores need strictly greater
  always_comb begin
    take    = cap_vld && ((cap_idx == 4'd0) || (ScoreData > run_max));
    nxt_max = take ? ScoreData : run_max;
    nxt_idx = take ? cap_idx   : run_idx;
  end

  // Scan sequencer: issues reads, folds returned scores, publishes the winner
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      ScoreRdEn <= 1'b0;
      ScoreAddr <= 4'd0;
      ClassOut  <= 4'd0;
      MaxScore  <= '0;
      run_max   <= '0;
      run_idx   <= 4'd0;
      cap_vld   <= 1'b0;
      cap_idx   <= 4'd0;
    end else begin
      Done    <= 1'b0;
      cap_vld <= 1'b0;
      cap_idx <= ScoreAddr;
      case (state)
        IDLE: begin
          // Abort has priority over a simultaneous Start
          if (Start && !Abort) begin
            state     <= FETCH;
            Busy      <= 1'b1;
            ScoreRdEn <= 1'b1;
            ScoreAddr <= 4'd0;
          end
        end
        FETCH: begin
          if (Abort) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            ScoreRdEn <= 1'b0;
            ScoreAddr <= 4'd0;
          end else begin
            cap_vld <= 1'b1;
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            if (ScoreAddr == LAST_ADDR) begin
              state     <= DRAIN;
              ScoreRdEn <= 1'b0;
              ScoreAddr <= 4'd0;
            end else begin
              ScoreAddr <= ScoreAddr + 4'd1;
            end
          end
        end
        DRAIN: begin
          // The last score arrives this cycle; fold it straight into the published result
          if (Abort) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            ScoreRdEn <= 1'b0;
            ScoreAddr <= 4'd0;
          end else begin
            run_max  <= nxt_max;
            run_idx  <= nxt_idx;
            ClassOut <= nxt_idx;
            MaxScore <= nxt_max;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          Busy      <= 1'b0;
          ScoreRdEn <= 1'b0;
          ScoreAddr <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_class_scan_ctrl.sv
// Directed bench for class_scan_ctrl with a one-cycle-latency score bank model.
module tb_class_scan_ctrl;

  localparam int NC = 10;
  localparam int SW = 26;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          Start;
  logic          Abort;
  logic          ScoreRdEn;
  logic [3:0]    ScoreAddr;
  logic [SW-1:0] ScoreData;
  logic          Busy;
  logic          Done;
  logic [3:0]    ClassOut;
  logic [SW-1:0] MaxScore;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] mem [16];

  typedef struct {
    logic [SW-1:0] sc [NC];
    logic [3:0]    cls;
    logic [SW-1:0] mx;
  } vec_t;

  vec_t vecs [NV];

  class_scan_ctrl #(.NUM_CLASSES(NC), .SCORE_W(SW)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .Start(Start), .Abort(Abort),
    .ScoreRdEn(ScoreRdEn), .ScoreAddr(ScoreAddr), .ScoreData(ScoreData),
    .Busy(Busy), .Done(Done), .ClassOut(ClassOut), .MaxScore(MaxScore)
  );

  always #5 clk = ~clk;

  // Score bank: data for the address presented appears the following cycle
  always @(posedge clk) begin
    if (ScoreRdEn) ScoreData <= mem[ScoreAddr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [SW-1:0] s0, s1, s2, s3, s4, s5, s6, s7, s8, s9,
                               input logic [3:0] c, input logic [SW-1:0] m);
    vec_t v;
    v.sc[0] = s0; v.sc[1] = s1; v.sc[2] = s2; v.sc[3] = s3; v.sc[4] = s4;
    v.sc[5] = s5; v.sc[6] = s6; v.sc[7] = s7; v.sc[8] = s8; v.sc[9] = s9;
    v.cls = c;
    v.mx  = m;
    return v;
  endfunction

  task automatic load(input int v);
    for (int i = 0; i < 16; i++) mem[i] = (i < NC) ? vecs[v].sc[i] : '0;
  endtask

  // Full scan: checks read sequence, Busy span, latency, result and one-cycle Done
  task automatic scan(input string tag, input logic [3:0] ecls, input logic [SW-1:0] emx);
    int c;
    int bc;
    int bad;
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    bad = 0;
    if (!(Busy && ScoreRdEn && ScoreAddr == 4'd0)) bad++;
    bc = Busy ? 1 : 0;
    c  = 0;
    while (!Done && c < 30) begin
      @(posedge clk); #1;
      c++;
      if (c < NC) begin
        if (!(ScoreRdEn && ScoreAddr == 4'(c))) bad++;
      end else if (ScoreRdEn || ScoreAddr != 4'd0) bad++;
      if (Busy) bc++;
    end
    chk({tag, "_rdseq"}, bad, 0);
    chk({tag, "_latency"}, c, NC + 1);
    chk({tag, "_busy_cycles"}, bc, NC + 1);
    chk({tag, "_class"}, ClassOut, ecls);
    chk({tag, "_max"}, MaxScore, emx);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {Done, ClassOut}, {1'b0, ecls});
  endtask

  initial begin
    int dn;
    int first;
    int second;

    vecs[0] = mkv(5, 26'h1FFFFFF, 3, 0, 9, 7, 2, 26'h2000000, 1, 4, 7, 26'h2000000);
    vecs[1] = mkv(100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 0, 100);
    vecs[2] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3] = mkv(10, 10, 10, 500, 10, 10, 10, 10, 500, 10, 3, 500);
    vecs[4] = mkv(10, 10, 10, 500, 10, 10, 10, 10, 500, 26'h3FFFFFF, 9, 26'h3FFFFFF);
    vecs[5] = mkv(7, 1, 1, 1, 1, 1, 1, 1, 1, 7, 0, 7);
    vecs[6] = mkv(1, 2, 3, 4, 5, 6, 7, 8, 9, 6, 8, 9);

    GlobalReset = 1'b0;
    Start       = 1'b0;
    Abort       = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {Busy, Done, ScoreRdEn, ScoreAddr, ClassOut, 6'd0, MaxScore},
        32'd0);
    @(negedge clk);
    GlobalReset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", {Busy, Done, ScoreRdEn}, 3'b000);

    // Table of scans
    for (int v = 0; v < NV; v++) begin
      load(v);
      scan($sformatf("vec%0d", v), vecs[v].cls, vecs[v].mx);
    end

    // Abort+Start together in IDLE: stays idle
    @(negedge clk);
    Start = 1'b1;
    Abort = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    Abort = 1'b0;
    chk("abort_start_idle", {Busy, ScoreRdEn, Done}, 3'b000);

    // Establish ClassOut=7, then abort on the 5th FETCH cycle
    load(0);
    scan("pre_abort", 4'd7, 26'h2000000);
    load(4);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    Abort = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    chk("abort_fetch_outs", {Busy, ScoreRdEn, Done, ScoreAddr}, 7'd0);
    chk("abort_fetch_class", ClassOut, 7);
    chk("abort_fetch_max", MaxScore, 32'h2000000);
    dn = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (Done) dn++;
    end
    chk("abort_no_done", dn, 0);
    scan("post_abort", 4'd9, 26'h3FFFFFF);

    // Abort on the completion edge: no Done, results held
    load(0);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (NC) @(posedge clk);
    #1;
    Abort = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    chk("abort_cmpl_done", {Done, Busy}, 2'b00);
    chk("abort_cmpl_result", {ClassOut, MaxScore}, {4'd9, 26'h3FFFFFF});

    // Asynchronous reset in the middle of FETCH
    load(0);
    @(negedge clk);
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("async_reset_outs", {Busy, Done, ScoreRdEn, ScoreAddr, ClassOut, 6'd0, MaxScore},
        32'd0);
    @(negedge clk);
    GlobalReset = 1'b1;
    scan("post_reset", 4'd7, 26'h2000000);

    // Start held through Busy is ignored; Start on the Done cycle chains a second scan
    load(3);
    @(negedge clk);
    Start  = 1'b1;
    dn     = 0;
    first  = -1;
    second = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done) begin
        dn++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (first >= 0 && i == first + 1) Start = 1'b0;
    end
    Start = 1'b0;
    chk("b2b_first_done", first, NC + 1);
    chk("b2b_spacing", second - first, NC + 2);
    chk("b2b_done_count", dn, 2);
    chk("b2b_class", ClassOut, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global guard so a hung design still ends with a summary
  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/class_scan_ctrl.md
CLASS_SCAN_CTRL -- requirements
Module: class_scan_ctrl

Interface
REQ-001 Parameter NUM_CLASSES, default 10, number of class scores scanned per classification; SHALL be in the range 2..16.
REQ-002 Parameter SCORE_W, default 26, width of one class score in bits.
REQ-003 Port clk  input  1  single rising-edge clock for all state.
REQ-004 Port GlobalReset  input  1  reset, asynchronous, active-low.
REQ-005 Port Start  input  1  request one classification scan; sampled on rising clk.
REQ-006 Port Abort  input  1  synchronous cancel of the scan in progress.
REQ-007 Port ScoreRdEn  output  1  read strobe to the score bank.
REQ-008 Port ScoreAddr  output  4  class index being read.
REQ-009 Port ScoreData  input  SCORE_W  score returned by the bank, valid in the cycle after the matching ScoreRdEn/ScoreAddr cycle.
REQ-010 Port Busy  output  1  scan in progress.
REQ-011 Port Done  output  1  one-cycle pulse when a scan completes.
REQ-012 Port ClassOut  output  4  index of the winning class from the last completed scan.
REQ-013 Port MaxScore  output  SCORE_W  score of the winning class from the last completed scan.
REQ-014 All outputs SHALL be driven directly from registers.

Function
REQ-015 States: IDLE, FETCH, DRAIN; IDLE is the reset state.
REQ-016 IDLE: a Start sampled high with Abort low SHALL move the block to FETCH at that edge (edge E0), set Busy=1, ScoreRdEn=1, ScoreAddr=0.
REQ-017 FETCH: ScoreAddr SHALL increment by 1 per cycle through NUM_CLASSES-1 with ScoreRdEn=1; after address NUM_CLASSES-1 has been issued, the block SHALL enter DRAIN with ScoreRdEn=0 and ScoreAddr=0.
REQ-018 Capture: ScoreData for index k SHALL be sampled at edge E(k+2); the final score is sampled at E(NUM_CLASSES+1) while in DRAIN.
REQ-019 Running max: the first captured score (index 0) SHALL initialise the internal max unconditionally; each later score SHALL replace it only if it is strictly greater (unsigned compare, full SCORE_W bits). On ties the lower index wins.
REQ-020 Completion: at edge E(NUM_CLASSES+1) the block SHALL load ClassOut/MaxScore with the final winner, including the last score, set Done=1, set Busy=0, and return to IDLE. Latency from Start edge to Done = NUM_CLASSES+1 cycles (11 at default).
REQ-021 Done SHALL be high for exactly one cycle; ClassOut and MaxScore SHALL change only at completion and hold until the next completion.
REQ-022 Start while Busy=1 SHALL be ignored (no restart, no queueing).
REQ-023 Start in the cycle Done is high (state IDLE) SHALL be accepted normally, allowing back-to-back scans every NUM_CLASSES+2 cycles.
REQ-024 Abort high in FETCH or DRAIN SHALL, at the next edge, return the block to IDLE with Busy=0, ScoreRdEn=0, ScoreAddr=0, no Done, and ClassOut/MaxScore unchanged.
REQ-025 Abort and Start both high in IDLE: Abort wins, and the block stays in IDLE.
REQ-026 Abort coinciding with the completion edge: Abort wins, and no Done pulse or result update occurs.

Reset
REQ-027 GlobalReset low SHALL immediately force IDLE and set Busy, Done, ScoreRdEn to 0, ScoreAddr, ClassOut to 0, MaxScore and the internal max/index to 0, including when a scan is in progress.
REQ-028 After GlobalReset deasserts, the first Start sampled high SHALL begin a normal scan.

Verification
REQ-029 Scores idx0..9 = 5,0x1FFFFFF,3,0,9,7,2,0x2000000,1,4 -> ClassOut=7, MaxScore=0x2000000, Done exactly 11 cycles after the Start edge, Busy high 11 cycles.
REQ-030 All ten scores = 100 -> ClassOut=0, MaxScore=100; all scores 0 -> ClassOut=0, MaxScore=0.
REQ-031 Scores max 500 at idx3 and idx8, others 10; winner at idx9 = 0x3FFFFFF on the next scan -> first scan ClassOut=3; second scan ClassOut=9 (last-sample capture checked).
REQ-032 Abort at the 5th FETCH cycle after a completed scan with ClassOut=7 -> no Done, Busy=0 and ScoreRdEn=0 next cycle, ClassOut stays 7; a following Start completes normally.
REQ-033 GlobalReset pulsed low mid-FETCH -> all outputs 0 asynchronously; Start pulses during Busy ignored (Done count = 1 per accepted Start); Start on the Done cycle -> second Done 12 cycles after the first.
